// File: rtl/mips_lsu_pkg.sv
// Shared types and op-legality helper for the MIPS load/store unit.
// LWL/LWR are legal only when MIPS_LSU_LWLR_EN is defined.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10
    } lsu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    localparam int                   LANE_W    = 8;
    localparam int                   NUM_LANES = 4;
    localparam logic [NUM_LANES-1:0] ALL_LANES = '1;

    function automatic logic op_legal(input logic [3:0] op, input logic [1:0] k);
        logic ok;
        case (op)
            OP_LB, OP_LBU, OP_SB: ok = 1'b1;
            OP_LH, OP_LHU, OP_SH: ok = ~k[0];
            OP_LW, OP_SW:         ok = (k == 2'b00);
`ifdef MIPS_LSU_LWLR_EN
            OP_LWL, OP_LWR:       ok = 1'b1;
`endif
            default:              ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mips_lsu_align.sv
// Combinational lane steering for stores and big-endian extraction for loads.
// LWL/LWR merge logic exists only when MIPS_LSU_LWLR_EN is defined.
module mips_lsu_align
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  i_st_op,
    input  logic [1:0]  i_st_k,
    input  logic [31:0] i_st_rt,
    output logic [3:0]  o_st_byte_en,
    output logic [31:0] o_st_wdata,
    input  logic [3:0]  i_ld_op,
    input  logic [1:0]  i_ld_k,
    input  logic [31:0] i_ld_word,
    input  logic [31:0] i_ld_rt_old,
    output logic [31:0] o_ld_result
);

    logic [31:0] w_rt_swap;
    logic [1:0]  w_lane_rev;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    // Write lanes count up from bit 0, so the most significant rt byte lands in lane 0.
    assign w_rt_swap  = {i_st_rt[7:0], i_st_rt[15:8], i_st_rt[23:16], i_st_rt[31:24]};
    assign w_lane_rev = ~i_ld_k;
    assign w_ld_byte  = i_ld_word[LANE_W*w_lane_rev +: LANE_W];
    assign w_ld_half  = i_ld_k[1] ? i_ld_word[15:0] : i_ld_word[31:16];

`ifdef MIPS_LSU_LWLR_EN
    logic [4:0] w_sh_l;
    logic [4:0] w_sh_r;
    assign w_sh_l = {i_ld_k, 3'b000};
    assign w_sh_r = {w_lane_rev, 3'b000};
`else
    logic [31:0] w_unused_rt_old;
    assign w_unused_rt_old = i_ld_rt_old;
`endif

    always_comb begin
        o_st_byte_en = '0;
        o_st_wdata   = '0;
        case (i_st_op)
            OP_SB: begin
                o_st_byte_en = 4'b0001 << i_st_k;
                o_st_wdata[LANE_W*i_st_k +: LANE_W] = i_st_rt[7:0];
            end
            OP_SH: begin
                o_st_byte_en = i_st_k[1] ? 4'b1100 : 4'b0011;
                o_st_wdata   = i_st_k[1] ? {w_rt_swap[31:16], 16'h0000}
                                         : {16'h0000, w_rt_swap[31:16]};
            end
            OP_SW: begin
                o_st_byte_en = ALL_LANES;
                o_st_wdata   = w_rt_swap;
            end
            default: ;
        endcase
    end

    always_comb begin
        o_ld_result = '0;
        case (i_ld_op)
            OP_LB:  o_ld_result = {{24{w_ld_byte[7]}}, w_ld_byte};
            OP_LBU: o_ld_result = {24'h000000, w_ld_byte};
            OP_LH:  o_ld_result = {{16{w_ld_half[15]}}, w_ld_half};
            OP_LHU: o_ld_result = {16'h0000, w_ld_half};
            OP_LW:  o_ld_result = i_ld_word;
`ifdef MIPS_LSU_LWLR_EN
            OP_LWL: o_ld_result = (i_ld_word << w_sh_l)
                                | (i_ld_rt_old & ((32'h1 << w_sh_l) - 32'h1));
            OP_LWR: o_ld_result = (i_ld_word >> w_sh_r)
                                | (i_ld_rt_old & ~(32'hFFFF_FFFF >> w_sh_r));
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: one request at a time, word-aligned memory access, one response each.
// Define MIPS_LSU_LWLR_EN to make LWL/LWR legal.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int READ_LATENCY = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam logic [2:0] CNT_LAST = 3'(READ_LATENCY - 1);

    lsu_state_e  r_state;
    lsu_state_e  w_state_nxt;
    logic [3:0]  r_op;
    logic [1:0]  r_k;
    logic [31:0] r_rt_old;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem_address;
    logic        r_mem_wr_en;
    logic        r_mem_read_en;
    logic [3:0]  r_mem_byte_en;
    logic [31:0] r_mem_data_in;

    logic        w_accept;
    logic        w_legal;
    logic        w_rd_done;
    logic [3:0]  w_st_byte_en;
    logic [31:0] w_st_wdata;
    logic [31:0] w_ld_result;

    assign w_accept  = req_valid && (r_state == ST_IDLE);
    assign w_legal   = op_legal(req_op, req_addr[1:0]);
    assign w_rd_done = (r_state == ST_WAIT) && (r_cnt == CNT_LAST);

    assign req_ready   = (r_state == ST_IDLE);
    assign resp_valid  = (r_state == ST_RESP);
    assign resp_rdata  = r_rdata;
    assign resp_err    = r_err;
    assign mem_address = r_mem_address;
    assign mem_wr_en   = r_mem_wr_en;
    assign mem_read_en = r_mem_read_en;
    assign mem_byte_en = r_mem_byte_en;
    assign mem_data_in = r_mem_data_in;

    // Store steering is taken from the live request at acceptance; load extraction from latched state.
    mips_lsu_align u_align (
        .i_st_op      (req_op),
        .i_st_k       (req_addr[1:0]),
        .i_st_rt      (req_wdata),
        .o_st_byte_en (w_st_byte_en),
        .o_st_wdata   (w_st_wdata),
        .i_ld_op      (r_op),
        .i_ld_k       (r_k),
        .i_ld_word    (mem_data_out),
        .i_ld_rt_old  (r_rt_old),
        .o_ld_result  (w_ld_result)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_legal ? ST_ISSUE : ST_RESP;
            ST_ISSUE: w_state_nxt = r_op[3] ? ST_RESP : ST_WAIT;
            ST_WAIT:  if (w_rd_done) w_state_nxt = ST_RESP;
            ST_RESP:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op          <= '0;
            r_k           <= '0;
            r_rt_old      <= '0;
            r_cnt         <= '0;
            r_rdata       <= '0;
            r_err         <= 1'b0;
            r_mem_address <= '0;
            r_mem_wr_en   <= 1'b0;
            r_mem_read_en <= 1'b0;
            r_mem_byte_en <= '0;
            r_mem_data_in <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op     <= req_op;
                        r_k      <= req_addr[1:0];
                        r_rt_old <= req_rt_old;
                        r_cnt    <= '0;
                        if (w_legal) begin
                            r_mem_address <= {req_addr[31:2], 2'b00};
                            if (req_op[3]) begin
                                r_mem_wr_en   <= 1'b1;
                                r_mem_byte_en <= w_st_byte_en;
                                r_mem_data_in <= w_st_wdata;
                            end else begin
                                r_mem_read_en <= 1'b1;
                                r_mem_byte_en <= ALL_LANES;
                            end
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_mem_wr_en   <= 1'b0;
                    r_mem_read_en <= 1'b0;
                    r_mem_byte_en <= '0;
                end
                ST_WAIT: begin
                    if (w_rd_done) begin
                        r_rdata <= w_ld_result;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                ST_RESP: begin
                    r_rdata <= '0;
                    r_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_lsu.sv
// Directed, table-driven bench for mips_lsu with a byte-addressed memory model (READ_LATENCY=3).
module tb_mips_lsu;

    localparam int RL = 3;

    localparam logic [3:0] LB  = 4'd0, LBU = 4'd1, LH  = 4'd2, LHU = 4'd3, LW = 4'd4;
    localparam logic [3:0] LWL = 4'd5, LWR = 4'd6, SB  = 4'd8, SH  = 4'd9, SW = 4'd10;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rt_old;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        logic [3:0]  exp_be;
        logic [7:0]  exp_strb;
        logic        chk_din;
        logic [31:0] exp_din;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_rt_old;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic        mem_wr_en;
    logic        mem_read_en;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;

    int n_checks = 0;
    int n_errors = 0;
    vec_t vecs[$];

    mips_lsu #(.READ_LATENCY(RL)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rt_old   (req_rt_old),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_address  (mem_address),
        .mem_wr_en    (mem_wr_en),
        .mem_read_en  (mem_read_en),
        .mem_byte_en  (mem_byte_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Byte memory: write lane i -> mem[addr+i] from bits [8i+7:8i]; read data valid only RL cycles after the strobe.
    logic [7:0]  mem [0:1023];
    logic [31:0] pend_word = '0;
    int          age = 0;
    logic [9:0]  ma;
    assign ma = mem_address[9:0];

    always @(posedge clk) begin
        if (mem_wr_en) begin
            for (int i = 0; i < 4; i++)
                if (mem_byte_en[i]) mem[ma + 10'(i)] <= mem_data_in[8*i +: 8];
        end
        if (mem_read_en) begin
            pend_word <= {mem[ma], mem[ma + 10'd1], mem[ma + 10'd2], mem[ma + 10'd3]};
            age <= 1;
        end else if (age == RL) begin
            age <= 0;
        end else if (age != 0) begin
            age <= age + 1;
        end
    end

    assign mem_data_out = (age == RL) ? pend_word : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_st(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                          input logic [3:0] be, input logic [31:0] din);
        vec_t v;
        v = '{op, addr, rt, 32'h0, 32'h0, 1'b0, 2, be, 8'h10, 1'b1, din};
        vecs.push_back(v);
    endtask

    task automatic add_ld(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt_old,
                          input logic [31:0] exp);
        vec_t v;
        v = '{op, addr, 32'h0, rt_old, exp, 1'b0, 2 + RL, 4'hF, 8'h01, 1'b0, 32'h0};
        vecs.push_back(v);
    endtask

    task automatic add_err(input logic [3:0] op, input logic [31:0] addr);
        vec_t v;
        v = '{op, addr, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b1, 1, 4'h0, 8'h00, 1'b0, 32'h0};
        vecs.push_back(v);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          lat;
        int          wr_cyc;
        int          rd_cyc;
        int          busy_ready;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  iss_be;
        logic [31:0] iss_addr;
        logic [31:0] iss_din;
        string       tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        check({tag, " ready_before"}, {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_op     = v.op;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        req_rt_old = v.rt_old;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; wr_cyc = 0; rd_cyc = 0; busy_ready = 0;
        rdata = '0; err = 1'b0; iss_be = '0; iss_addr = '0; iss_din = '0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 1) begin
                iss_be   = mem_byte_en;
                iss_addr = mem_address;
                iss_din  = mem_data_in;
            end
            if (mem_wr_en)   wr_cyc++;
            if (mem_read_en) rd_cyc++;
            if (req_ready)   busy_ready++;
            if (resp_valid) begin
                lat   = n;
                rdata = resp_rdata;
                err   = resp_err;
            end
        end
        check({tag, " latency"}, lat, v.exp_lat);
        check({tag, " rdata"}, rdata, v.exp_rdata);
        check({tag, " err"}, {31'h0, err}, {31'h0, v.exp_err});
        check({tag, " issue_byte_en"}, {28'h0, iss_be}, {28'h0, v.exp_be});
        check({tag, " strobe_cycles"}, wr_cyc * 16 + rd_cyc, {24'h0, v.exp_strb});
        check({tag, " ready_while_busy"}, busy_ready, 0);
        if (!v.exp_err) check({tag, " mem_address"}, iss_addr, {v.addr[31:2], 2'b00});
        if (v.chk_din)  check({tag, " mem_data_in"}, iss_din, v.exp_din);
        @(negedge clk);
        check({tag, " after_resp"}, {28'h0, resp_valid, req_ready, resp_err, (resp_rdata != 0)},
              32'h4);
    endtask

    // Accepts an LW and asserts reset in cycle A+at_cycle (1=ISSUE, 2=WAIT).
    task automatic reset_abort(input int at_cycle, input string tag);
        int seen;
        @(negedge clk);
        req_valid = 1'b1; req_op = LW; req_addr = 32'h100;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (at_cycle) @(negedge clk);
        check({tag, " rd_before_reset"}, {31'h0, mem_read_en}, {31'h0, (at_cycle == 1)});
        reset = 1'b1;
        #1;
        check({tag, " strobes_async"}, {27'h0, mem_read_en, mem_byte_en}, 32'h0);
        check({tag, " ready_async"}, {31'h0, req_ready}, 32'h1);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        reset = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || mem_read_en) seen++;
        end
        check({tag, " no_resp"}, seen, 0);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b1; req_op = SW; req_addr = 32'h100;
        req_wdata = 32'hCAFE_F00D; req_rt_old = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_hold outputs", {25'h0, mem_wr_en, mem_read_en, mem_byte_en, resp_valid},
              32'h0);
        check("reset_hold ready", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset strobes", {26'h0, mem_wr_en, mem_read_en, mem_byte_en}, 32'h0);
        check("post_reset resp", {30'h0, resp_valid, resp_err}, 32'h0);
        check("post_reset ready", {31'h0, req_ready}, 32'h1);
        check("post_reset rdata", resp_rdata, 32'h0);
        check("post_reset address", mem_address, 32'h0);
        check("post_reset data_in", mem_data_in, 32'h0);

        add_st(SW, 32'h100, 32'h1234_5678, 4'b1111, 32'h7856_3412);
        add_ld(LW, 32'h100, 32'h0, 32'h1234_5678);
        add_st(SB, 32'h102, 32'h0000_00AB, 4'b0100, 32'h00AB_0000);
        add_ld(LB, 32'h102, 32'h0, 32'hFFFF_FFAB);
        add_ld(LBU, 32'h102, 32'h0, 32'h0000_00AB);
        add_ld(LW, 32'h100, 32'h0, 32'h1234_AB78);
        add_st(SW, 32'h200, 32'h1122_8001, 4'b1111, 32'h0180_2211);
        add_ld(LH, 32'h202, 32'h0, 32'hFFFF_8001);
        add_ld(LHU, 32'h202, 32'h0, 32'h0000_8001);
        add_ld(LB, 32'h203, 32'h0, 32'h0000_0001);
        add_ld(LB, 32'h202, 32'h0, 32'hFFFF_FF80);
        add_ld(LBU, 32'h200, 32'h0, 32'h0000_0011);
        add_st(SH, 32'h200, 32'h0000_BEEF, 4'b0011, 32'h0000_EFBE);
        add_ld(LH, 32'h200, 32'h0, 32'hFFFF_BEEF);
        add_ld(LHU, 32'h200, 32'h0, 32'h0000_BEEF);
        add_st(SH, 32'h202, 32'h0000_1234, 4'b1100, 32'h3412_0000);
        add_ld(LW, 32'h200, 32'h0, 32'hBEEF_1234);
        add_err(LW, 32'h102);
        add_err(4'd7, 32'h100);
        add_err(LH, 32'h201);
        add_err(SH, 32'h203);
        add_err(SW, 32'h202);
        add_err(4'd11, 32'h100);
        add_err(4'd15, 32'h100);
        add_st(SW, 32'h100, 32'h1122_3344, 4'b1111, 32'h4433_2211);
`ifdef MIPS_LSU_LWLR_EN
        add_ld(LWL, 32'h101, 32'hAABB_CCDD, 32'h2233_44DD);
        add_ld(LWR, 32'h101, 32'hAABB_CCDD, 32'hAABB_1122);
        add_ld(LWL, 32'h100, 32'hAABB_CCDD, 32'h1122_3344);
        add_ld(LWL, 32'h103, 32'hAABB_CCDD, 32'h44BB_CCDD);
        add_ld(LWR, 32'h103, 32'hAABB_CCDD, 32'h1122_3344);
        add_ld(LWR, 32'h100, 32'hAABB_CCDD, 32'hAABB_CC11);
`else
        add_err(LWL, 32'h101);
        add_err(LWR, 32'h101);
        add_err(LWL, 32'h100);
`endif

        foreach (vecs[i]) run_vec(vecs[i], i);

        reset_abort(2, "abort_wait");
        reset_abort(1, "abort_issue");

        begin
            vec_t v;
            v = '{LW, 32'h100, 32'h0, 32'h0, 32'h1122_3344, 1'b0, 2 + RL, 4'hF, 8'h01, 1'b0, 32'h0};
            run_vec(v, 99);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
